// File: rtl/bpsk_transmitter_if.sv
// Handshake and sample bus of the BPSK transmitter: payload write port plus modulated output.
interface bpsk_transmitter_if #(
  parameter int SIGNAL_WIDTH  = 8,
  parameter int PAYLOAD_WIDTH = 32
);
  logic [PAYLOAD_WIDTH-1:0]       payload;
  logic                           w;
  logic                           ready;
  logic signed [SIGNAL_WIDTH-1:0] sig;
  logic                           active;
  logic                           done;

  modport master (output payload, output w, input ready, input sig, input active, input done);
  modport slave  (input payload, input w, output ready, output sig, output active, output done);
endinterface

// File: rtl/bpsk_transmitter.sv
// BPSK frame transmitter: Barker preamble, MSB-first payload, then a silent guard interval.
module bpsk_transmitter #(
  parameter int                        SIGNAL_WIDTH     = 8,
  parameter int                        PAYLOAD_WIDTH    = 32,
  parameter int                        PREAMBLE_WIDTH   = 13,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE         = 13'b1111100110101,
  parameter int                        HALF_PERIOD      = 4,
  parameter int                        CARRIERS_PER_BIT = 2,
  parameter int                        GUARD_BITS       = 4
) (
  input  logic             clk,
  input  logic             rst,
  bpsk_transmitter_if.slave bus
);
  localparam int BIT_SAMPLES = 2 * HALF_PERIOD * CARRIERS_PER_BIT;
  localparam int S_W         = $clog2(BIT_SAMPLES);
  localparam int MAX_A       = (PREAMBLE_WIDTH > PAYLOAD_WIDTH) ? PREAMBLE_WIDTH : PAYLOAD_WIDTH;
  localparam int MAX_BITS    = (MAX_A > GUARD_BITS) ? MAX_A : GUARD_BITS;
  localparam int B_W         = $clog2(MAX_BITS + 1);

  localparam logic [SIGNAL_WIDTH-1:0] AMP     = {1'b0, {(SIGNAL_WIDTH-1){1'b1}}};
  localparam logic [SIGNAL_WIDTH-1:0] NEG_AMP = ~AMP + 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_PAY   = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam logic [S_W-1:0] S_LAST     = S_W'(BIT_SAMPLES - 1);
  localparam logic [S_W-1:0] HALF       = S_W'(HALF_PERIOD);
  localparam logic [B_W-1:0] PRE_LAST   = B_W'(PREAMBLE_WIDTH - 1);
  localparam logic [B_W-1:0] PAY_LAST   = B_W'(PAYLOAD_WIDTH - 1);
  localparam logic [B_W-1:0] GUARD_LAST = B_W'(GUARD_BITS - 1);

  logic [1:0]                state;
  logic [S_W-1:0]            s;
  logic [B_W-1:0]            bitc;
  logic [PREAMBLE_WIDTH-1:0] pre_sr;
  logic [PAYLOAD_WIDTH-1:0]  pay_sr;
  logic [SIGNAL_WIDTH-1:0]   sig_q;
  logic                      done_q;

  logic                      sym_end;
  logic [S_W-1:0]            s_next;
  logic [S_W-1:0]            half_idx;
  logic                      half;
  logic                      cur_bit;
  logic [SIGNAL_WIDTH-1:0]   mod_sample;

  assign sym_end  = (s == S_LAST);
  assign s_next   = sym_end ? '0 : s + 1'b1;
  assign half_idx = s / HALF;
  assign half     = half_idx[0];
  assign cur_bit  = (state == ST_PRE) ? pre_sr[PREAMBLE_WIDTH-1] : pay_sr[PAYLOAD_WIDTH-1];
  // Positive when the bit and the carrier half differ: bit 1 starts high, bit 0 starts low.
  assign mod_sample = (cur_bit ^ half) ? AMP : NEG_AMP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      s      <= '0;
      bitc   <= '0;
      pre_sr <= '0;
      pay_sr <= '0;
      sig_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          sig_q <= '0;
          if (bus.w) begin
            state  <= ST_PRE;
            s      <= '0;
            bitc   <= '0;
            pre_sr <= PREAMBLE;
            pay_sr <= bus.payload;
          end
        end
        ST_PRE: begin
          sig_q <= mod_sample;
          s     <= s_next;
          if (sym_end) begin
            pre_sr <= pre_sr << 1;
            if (bitc == PRE_LAST) begin
              bitc  <= '0;
              state <= ST_PAY;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end
        end
        ST_PAY: begin
          sig_q <= mod_sample;
          s     <= s_next;
          if (sym_end) begin
            pay_sr <= pay_sr << 1;
            if (bitc == PAY_LAST) begin
              bitc  <= '0;
              state <= ST_GUARD;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end
        end
        default: begin
          sig_q <= '0;
          s     <= s_next;
          if (sym_end) begin
            if (bitc == GUARD_LAST) begin
              bitc   <= '0;
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.sig    = sig_q;
  assign bus.ready  = (state == ST_IDLE);
  assign bus.active = (state != ST_IDLE);
  assign bus.done   = done_q;
endmodule

// File: tb/tb_bpsk_transmitter.sv
// Self-checking bench for bpsk_transmitter: constant vectors, random frames vs a frame-level model.
module tb_bpsk_transmitter;
  localparam int SW   = 8;
  localparam int PW   = 32;
  localparam int PRW  = 13;
  localparam logic [PRW-1:0] PRE = 13'b1111100110101;
  localparam int HP   = 4;
  localparam int CPB  = 2;
  localparam int GB   = 4;
  localparam int BS   = 2 * HP * CPB;
  localparam int N    = (PRW + PW) * BS;
  localparam int G    = GB * BS;
  localparam int NG   = N + G;
  localparam int AMP  = (1 << (SW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bpsk_transmitter_if #(.SIGNAL_WIDTH(SW), .PAYLOAD_WIDTH(PW)) bus ();

  bpsk_transmitter #(
    .SIGNAL_WIDTH(SW), .PAYLOAD_WIDTH(PW), .PREAMBLE_WIDTH(PRW), .PREAMBLE(PRE),
    .HALF_PERIOD(HP), .CARRIERS_PER_BIT(CPB), .GUARD_BITS(GB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cap_sig    [0:NG];
  int cap_ready  [0:NG];
  int cap_active [0:NG];
  int cap_done   [0:NG];

  typedef struct {
    int k;
    int sig_req;
  } vec_t;
  vec_t vecs[$];

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Frame sample n: frame bit = preamble then payload MSB first; sign from bit vs carrier half.
  function automatic int model_sample(input logic [PW-1:0] p, input int n);
    logic [PRW+PW-1:0] frame;
    int sym, sidx, h, b;
    frame = {PRE, p};
    sym   = n / BS;
    sidx  = n % BS;
    h     = (sidx / HP) % 2;
    b     = int'(frame[PRW + PW - 1 - sym]);
    if ((b == 1 && h == 0) || (b == 0 && h == 1)) return AMP;
    return -AMP;
  endfunction

  task automatic wait_ready();
    int waited = 0;
    while (bus.ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait_timeout", int'(waited < 2000), 1);
  endtask

  // Runs one frame from E0 through E0+N+G, capturing outputs after every edge and checking the model.
  task automatic run_frame(input logic [PW-1:0] p, input bit busy, input bit chain,
                           input logic [PW-1:0] next_p, input bit pre_asserted);
    if (!pre_asserted) begin
      wait_ready();
      bus.payload = p;
      bus.w       = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k <= NG; k++) begin
      @(negedge clk);
      if (k == 0) bus.w = 1'b0;
      if (busy && k == 99) begin
        bus.w       = 1'b1;
        bus.payload = '0;
      end
      if (busy && k == 100) bus.w = 1'b0;
      if (chain && k == NG) begin
        bus.w       = 1'b1;
        bus.payload = next_p;
      end
      cap_sig[k]    = int'($signed(bus.sig));
      cap_ready[k]  = int'(bus.ready);
      cap_active[k] = int'(bus.active);
      cap_done[k]   = int'(bus.done);
    end
    for (int k = 0; k <= NG; k++) begin
      int req;
      req = (k >= 1 && k <= N) ? model_sample(p, k - 1) : 0;
      check($sformatf("sig@E0+%0d", k), cap_sig[k], req);
      check($sformatf("ready@E0+%0d", k), cap_ready[k], int'(k == NG));
      check($sformatf("active@E0+%0d", k), cap_active[k], int'(k != NG));
      check($sformatf("done@E0+%0d", k), cap_done[k], int'(k == NG));
    end
  endtask

  initial begin
    logic [PW-1:0] r0, r1, r2;
    bus.w       = 1'b0;
    bus.payload = '0;

    // Reset state and idle silence
    repeat (3) @(negedge clk);
    check("rst_sig", int'($signed(bus.sig)), 0);
    check("rst_ready", int'(bus.ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("reset_sig", int'($signed(bus.sig)), 0);
    check("reset_ready", int'(bus.ready), 1);
    check("reset_active", int'(bus.active), 0);
    check("reset_done", int'(bus.done), 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("idle_sig", int'($signed(bus.sig)), 0);
    end

    // Known word with a busy write at E0+100
    vecs.push_back('{1, 127});   vecs.push_back('{4, 127});
    vecs.push_back('{5, -127});  vecs.push_back('{8, -127});
    vecs.push_back('{9, 127});   vecs.push_back('{16, -127});
    vecs.push_back('{81, -127}); vecs.push_back('{209, 127});
    vecs.push_back('{225, -127}); vecs.push_back('{720, -127});
    vecs.push_back('{721, 0});   vecs.push_back('{784, 0});
    run_frame(32'hA5A5A5A5, 1'b1, 1'b0, '0, 1'b0);
    foreach (vecs[i])
      check($sformatf("vec_sig@E0+%0d", vecs[i].k), cap_sig[vecs[i].k], vecs[i].sig_req);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("no_extra_frame_active", int'(bus.active), 0);
      check("no_extra_frame_done", int'(bus.done), 0);
    end

    // Random words, the last pair back-to-back
    r0 = PW'($urandom);
    r1 = PW'($urandom);
    r2 = PW'($urandom);
    run_frame(r0, 1'b0, 1'b0, '0, 1'b0);
    run_frame(r1, 1'b0, 1'b1, r2, 1'b0);
    run_frame(r2, 1'b0, 1'b0, '0, 1'b1);

    // Mid-frame abort
    wait_ready();
    bus.payload = PW'($urandom);
    bus.w       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.w = 1'b0;
    check("abort_prestart_active", int'(bus.active), 1);
    repeat (299) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_sig", int'($signed(bus.sig)), 0);
    check("abort_ready", int'(bus.ready), 1);
    check("abort_active", int'(bus.active), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      check("post_abort_done", int'(bus.done), 0);
      check("post_abort_sig", int'($signed(bus.sig)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
